// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, FSM encoding and round constants for the AddRoundKey stage
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    COLLECT = 2'd2,
    OUT     = 2'd3
  } ark_fsm_e;

  localparam byte_t RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte k of a 128-bit state/key, byte 0 in the most significant position.
  function automatic byte_t state_byte(input state_t s, input logic [3:0] k);
    logic [6:0] base;
    base = 7'd127 - {k, 3'b000};
    return s[base -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t a_i,
  output byte_t s_o
);

  // Entry 0 sits in the top byte; row n holds entries 16n..16n+15.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base = 11'h7ff - {a_i, 3'b000};
  assign s_o  = SBOX[base -: 8];

endmodule

// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - byte-serial AES-128 AddRoundKey with on-the-fly key expansion
// Optional debug ports dbg_round_key/dbg_fsm enabled by `define ARK_DEBUG_KEY_EN.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         last_round
`ifdef ARK_DEBUG_KEY_EN
  ,
  output logic [127:0] dbg_round_key,
  output logic [1:0]   dbg_fsm
`endif
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  ark_fsm_e   fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  state_t     key_q, key_d;
  state_t     buf_q, buf_d;

  logic [31:0] rot_w3;
  logic [31:0] sub_rot;
  logic [31:0] t_word;
  logic [31:0] new_word;
  logic [6:0]  wr_base;
  logic [6:0]  prev_base;
  logic [6:0]  byte_base;

  // Expansion is done in place: word j is overwritten at step j, so at step 0
  // word 3 is still the previous round's w3 and at step j>0 word j-1 is already new.
  assign rot_w3    = {key_q[23:0], key_q[31:24]};
  assign wr_base   = 7'd127 - {step_q, 5'b00000};
  assign prev_base = 7'd127 - {step_q - 2'd1, 5'b00000};
  assign byte_base = 7'd127 - {cnt_q, 3'b000};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a_i (rot_w3[8*i +: 8]),
      .s_o (sub_rot[8*i +: 8])
    );
  end

  assign t_word   = (step_q == 2'd0) ? (sub_rot ^ {RCON[rnd_q - 4'd1], 24'h000000})
                                     : key_q[prev_base -: 32];
  assign new_word = key_q[wr_base -: 32] ^ t_word;

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    cnt_d  = cnt_q;
    step_d = step_q;
    key_d  = key_q;
    buf_d  = buf_q;

    case (fsm_q)
      IDLE: begin
      end
      EXPAND: begin
        key_d[wr_base -: 32] = new_word;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          fsm_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          buf_d[byte_base -: 8] = in_byte ^ state_byte(key_q, cnt_q);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            fsm_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d = 4'd0;
          if (rnd_q == LAST_RND) begin
            fsm_d = IDLE;
          end else begin
            rnd_d  = rnd_q + 4'd1;
            step_d = 2'd0;
            fsm_d  = EXPAND;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase

    // A new key overrides whatever the stage was doing, including a held block.
    if (key_load) begin
      key_d  = key_in;
      rnd_d  = 4'd1;
      cnt_d  = 4'd0;
      step_d = 2'd0;
      fsm_d  = EXPAND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      rnd_q  <= 4'd0;
      cnt_q  <= 4'd0;
      step_q <= 2'd0;
      key_q  <= '0;
      buf_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      key_q  <= key_d;
      buf_q  <= buf_d;
    end
  end

  assign in_ready   = (fsm_q == COLLECT);
  assign out_valid  = (fsm_q == OUT);
  assign out_state  = buf_q;
  assign out_round  = rnd_q;
  assign last_round = out_valid && (rnd_q == LAST_RND);

`ifdef ARK_DEBUG_KEY_EN
  assign dbg_round_key = key_q;
  assign dbg_fsm       = fsm_q;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - directed-vector bench with a key-schedule/scoreboard model
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         last_round;
`ifdef ARK_DEBUG_KEY_EN
  logic [127:0] dbg_round_key;
  logic [1:0]   dbg_fsm;
`endif

  add_round_key_stage dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key_in     (key_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_round  (out_round),
    .last_round (last_round)
`ifdef ARK_DEBUG_KEY_EN
    ,
    .dbg_round_key (dbg_round_key),
    .dbg_fsm       (dbg_fsm)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] BLK2 = 128'h0466_81e5_e0cb_199a_48f8_d37a_2806_264c;

  typedef struct {
    logic [127:0] st;
    int           rnd;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cur_round;
  logic [127:0] cur_key;
  logic [7:0]   sb_tab [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // GF(2^8) model of the S-box: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Scoreboard: every cycle the DUT presents a block it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 128'(out_valid), 128'd0);
        end else begin
          chk("sb_out_state", out_state, exp_q[0].st);
          chk("sb_out_round", 128'(out_round), 128'(exp_q[0].rnd));
          chk("sb_last_round", 128'(last_round), 128'(exp_q[0].rnd == 10));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (last_round) begin
        chk("last_round_without_valid", 128'(last_round), 128'd0);
      end
    end
  end

  task automatic do_key_load(input logic [127:0] k, input bit with_byte);
    key_load = 1'b1;
    key_in   = k;
    if (with_byte) begin
      in_valid = 1'b1;
      in_byte  = 8'hff;
    end
    @(posedge clk); #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    cur_round = 1;
    cur_key   = k;
  endtask

  task automatic expect_ready_after(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    chk(nm, 128'(n), 128'd5);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    bit done  = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 200) begin
        chk("send_timeout", 128'(guard), 128'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input bit gaps, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(blk[127 - 8*k -: 8]);
    end
    if (nbytes == 16) begin
      exp_t e;
      e.st  = blk ^ round_key(cur_key, cur_round);
      e.rnd = cur_round;
      exp_q.push_back(e);
    end
  endtask

  task automatic take_out(output logic [127:0] st, output logic [3:0] rd);
    int guard = 0;
    bit done  = 1'b0;
    out_ready = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else begin
        guard++;
        if (guard > 100) begin
          chk("out_timeout", 128'(guard), 128'd0);
          done = 1'b1;
        end
      end
    end
    st = out_state;
    rd = out_round;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cur_round++;
  endtask

  initial begin
    logic [127:0] st;
    logic [127:0] held;
    logic [3:0]   rd;

    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

    rst       = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    in_valid  = 1'b0;
    in_byte   = '0;
    out_ready = 1'b0;
    cur_round = 0;
    cur_key   = '0;

    chk("model_sbox_00", 128'(sb_tab[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb_tab[8'h53]), 128'hed);
    chk("model_rk1", round_key(KEY, 1), 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("model_rk10", round_key(KEY, 10), 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: no key loaded, input traffic must be ignored
    @(negedge clk);
    chk("reset_out_state", out_state, 128'd0);
    chk("reset_out_round", 128'(out_round), 128'd0);
    in_valid = 1'b1;
    in_byte  = 8'h5a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 128'(in_ready), 128'd0);
      chk("idle_out_valid", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 2: FIPS-197 round 1 vector
    do_key_load(KEY, 1'b0);
    expect_ready_after("ready_latency_key_load");
    send_block(BLK2, 1'b0, 16);

    // 3: back-pressure in OUT
    @(negedge clk);
    chk("out_valid_after_byte15", 128'(out_valid), 128'd1);
    held     = out_state;
    in_valid = 1'b1;
    in_byte  = 8'haa;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      chk("hold_out_state", out_state, held);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    take_out(st, rd);
    chk("fips_round1_state", st, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    chk("fips_round1_round", 128'(rd), 128'd1);
    expect_ready_after("ready_latency_after_out");

    // 4: all ten rounds with zero input reproduce the key schedule
    do_key_load(KEY, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      send_block(128'd0, 1'b0, 16);
      take_out(st, rd);
      chk("zero_block_round", 128'(rd), 128'(r));
    end
    chk("round10_state", st, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_last_in_ready", 128'(in_ready), 128'd0);
      chk("after_last_out_valid", 128'(out_valid), 128'd0);
    end

    // 5: key_load mid-block discards the partial block and restarts at round 1
    do_key_load(KEY, 1'b0);
    send_block(128'h11223344_55667788_99aabbcc_ddeeff00, 1'b0, 16);
    take_out(st, rd);
    send_block(BLK2, 1'b0, 9);
    do_key_load(KEY, 1'b1);
    expect_ready_after("ready_latency_reload");
    send_block(BLK2, 1'b0, 16);
    take_out(st, rd);
    chk("reload_state", st, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    chk("reload_round", 128'(rd), 128'd1);

    // 6: gapped input, then reset in the middle of a block
    do_key_load(KEY, 1'b0);
    send_block(BLK2, 1'b1, 16);
    take_out(st, rd);
    chk("gapped_state", st, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
    send_block(BLK2, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_out_round", 128'(out_round), 128'd0);
    chk("rst_last_round", 128'(last_round), 128'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
